// File: rtl/aud_pkg.sv
// aud_pkg: types and constants shared by the audio player and the audio recorder
package aud_pkg;
    localparam int AUD_DATA_W = 16;
    typedef enum logic [2:0] {IDLE, WAIT_FRAME, SEND, HOLD, PAUSED} aud_state_t;
endpackage

// File: rtl/aud_lrc_edge.sv
// aud_lrc_edge: registers the codec LR clock and flags the left/right frame edges
//   clk   in  : BCLK
//   rst   in  : asynchronous active-high reset
//   lrc   in  : LR clock (low = left, high = right)
//   left  out : 1->0 transition seen this cycle (left frame starts)
//   right out : 0->1 transition seen this cycle (right frame starts)
module aud_lrc_edge (
    input  logic clk,
    input  logic rst,
    input  logic lrc,
    output logic left,
    output logic right
);
    logic lrc_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) lrc_q <= 1'b0;
        else     lrc_q <= lrc;
    assign left  = lrc_q & ~lrc;
    assign right = ~lrc_q & lrc;
endmodule

// File: rtl/aud_player.sv
// aud_player: one-entry sample buffer feeding an MSB-first serial DAC stream framed by LRC
//   i_clk        in  : BCLK
//   i_rst_n      in  : asynchronous active-high reset
//   i_lrc        in  : LR clock (low = left, high = right)
//   i_start      in  : pulse, begin or resume playback
//   i_pause      in  : pulse, pause after the current channel word
//   i_stop       in  : pulse, abort playback at once
//   i_valid      in  : i_data holds a sample
//   i_data       in  : two's-complement sample
//   o_ready      out : buffer empty and player active
//   o_aud_dacdat out : serial DAC data
//   o_underrun   out : sticky, a left frame began with an empty buffer
module aud_player
    import aud_pkg::*;
#(
    parameter int DATA_W    = AUD_DATA_W,
    parameter bit DUP_RIGHT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_aud_dacdat,
    output logic              o_underrun
);
    localparam int CW = $clog2(DATA_W);
    aud_state_t state, state_n;
    logic left, right, lrc_chg, last, load, pend, start_ok, clr, accept, smp_full;
    logic [DATA_W-1:0] smp, sr, held, ld_val;
    logic [CW-1:0] cnt;
    aud_lrc_edge u_lrc (
        .clk(i_clk),
        .rst(i_rst_n),
        .lrc(i_lrc),
        .left(left),
        .right(right)
    );
    assign lrc_chg      = left | right;
    assign last         = cnt == CW'(DATA_W - 1);
    assign start_ok     = i_start & ~i_pause & ~i_stop;
    assign clr          = start_ok & (state inside {IDLE, PAUSED});
    assign o_ready      = ~smp_full & (state != IDLE);
    assign accept       = i_valid & o_ready;
    assign o_aud_dacdat = (state == SEND) & sr[DATA_W-1];
    // left frames consume the buffer; right frames replay the held left word or stay silent
    assign ld_val = left ? (smp_full ? smp : '0) : (DUP_RIGHT ? held : '0);
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE, PAUSED: if (start_ok) state_n = WAIT_FRAME;
            WAIT_FRAME:
                if (i_pause) state_n = PAUSED;
                else if (left) begin
                    state_n = SEND;
                    load    = 1'b1;
                end
            SEND:
                // a pending pause lets the word finish (or be cut by a short frame) before stopping
                if (pend | i_pause) begin
                    if (lrc_chg | last) state_n = PAUSED;
                end else if (lrc_chg) load = 1'b1;
                else if (last) state_n = HOLD;
            HOLD:
                if (i_pause) state_n = PAUSED;
                else if (lrc_chg) begin
                    state_n = SEND;
                    load    = 1'b1;
                end
            default: state_n = IDLE;
        endcase
        if (i_stop) begin
            state_n = IDLE;
            load    = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst_n)
        if (i_rst_n) begin
            state      <= IDLE;
            pend       <= 1'b0;
            smp_full   <= 1'b0;
            smp        <= '0;
            sr         <= '0;
            held       <= '0;
            cnt        <= '0;
            o_underrun <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= (state_n == SEND) & (pend | i_pause);
            if (i_stop) smp_full <= 1'b0;
            else if (accept) begin
                smp_full <= 1'b1;
                smp      <= i_data;
            end else if (load & left) smp_full <= 1'b0;
            sr   <= i_stop ? '0 : load ? ld_val : (state == SEND) ? sr << 1 : sr;
            held <= i_stop ? '0 : (load & left) ? ld_val : held;
            cnt  <= (i_stop | load) ? '0 : (state == SEND && !last) ? cnt + CW'(1) : cnt;
            o_underrun <= (load & left & ~smp_full) | (o_underrun & ~clr);
        end
endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: randomized frame-level check of aud_player (DUP_RIGHT 1 and 0) against a word model
module tb_aud_player;
    localparam int E_NONE = 0, E_START = 1, E_PAUSE = 2, E_STOP = 3, E_STOPSTART = 4, E_RST = 5;
    logic clk = 1'b0, rst = 1'b1, lrc = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0, valid = 1'b0;
    logic [15:0] data = '0;
    logic rdy1, dat1, und1, rdy0, dat0, und0;
    int n_chk = 0, n_pass = 0;
    int mode = 0;
    logic m_full = 1'b0, m_und = 1'b0;
    logic [15:0] m_smp = '0, m_held = '0;
    always #5 clk = ~clk;
    aud_player #(.DATA_W(16), .DUP_RIGHT(1)) u_dup (
        .i_clk(clk), .i_rst_n(rst), .i_lrc(lrc), .i_start(start), .i_pause(pause),
        .i_stop(stop), .i_valid(valid), .i_data(data),
        .o_ready(rdy1), .o_aud_dacdat(dat1), .o_underrun(und1)
    );
    aud_player #(.DATA_W(16), .DUP_RIGHT(0)) u_zero (
        .i_clk(clk), .i_rst_n(rst), .i_lrc(lrc), .i_start(start), .i_pause(pause),
        .i_stop(stop), .i_valid(valid), .i_data(data),
        .o_ready(rdy0), .o_aud_dacdat(dat0), .o_underrun(und0)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // one LRC half-period of len cycles; mode: 0 idle, 1 waiting for left, 2 playing, 3 paused
    task automatic half(input int len, input int ev_at, input int ev, input int fill_at, input logic [15:0] fill);
        logic [15:0] e1, e0, w1, w0, keep, ones;
        int tail;
        bit is_left;
        bit rdy_m;
        lrc = ~lrc;
        is_left = !lrc;
        e1 = '0; e0 = '0; w1 = '0; w0 = '0; tail = 0;
        ones = 16'hFFFF;
        keep = ~(ones >> (len < 16 ? len : 16));
        if (is_left && (mode == 1 || mode == 2)) begin
            mode = 2;
            e1 = m_full ? m_smp : 16'h0;
            if (!m_full) m_und = 1'b1;
            m_held = e1;
            m_full = 1'b0;
            e0 = e1;
        end else if (!is_left && mode == 2) e1 = m_held;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            start = 1'b0; pause = 1'b0; stop = 1'b0; valid = 1'b0; rst = 1'b0;
            if (i < 16) begin
                w1[15-i] = dat1;
                w0[15-i] = dat0;
            end else tail += int'(dat1) + int'(dat0);
            if (i == fill_at) begin
                rdy_m = !m_full && mode != 0;
                chk("ready_fill", rdy1, rdy_m);
                if (rdy_m) begin
                    valid = 1'b1;
                    data = fill;
                    m_full = 1'b1;
                    m_smp = fill;
                end
            end
            if (i == ev_at) begin
                case (ev)
                    E_START: begin
                        start = 1'b1;
                        if (mode == 0 || mode == 3) begin
                            mode = 1;
                            m_und = 1'b0;
                        end
                    end
                    E_PAUSE: begin
                        pause = 1'b1;
                        if (mode == 1 || mode == 2) mode = 3;
                    end
                    E_STOP, E_STOPSTART: begin
                        stop = 1'b1;
                        start = (ev == E_STOPSTART);
                        mode = 0; m_full = 1'b0; m_held = '0;
                        e1 &= ~(ones >> (i + 1));
                        e0 &= ~(ones >> (i + 1));
                    end
                    E_RST: begin
                        rst = 1'b1;
                        #1;
                        chk("rst_dat", {dat1, dat0}, 2'b00);
                        chk("rst_ready", {rdy1, rdy0}, 2'b00);
                        chk("rst_underrun", {und1, und0}, 2'b00);
                        mode = 0; m_full = 1'b0; m_held = '0; m_und = 1'b0;
                        e1 &= ~(ones >> (i + 1));
                        e0 &= ~(ones >> (i + 1));
                    end
                    default: ;
                endcase
            end
        end
        chk(is_left ? "left_dup" : "right_dup", w1, e1 & keep);
        chk(is_left ? "left_zero" : "right_zero", w0, e0 & keep);
        chk("tail_zero", tail, 0);
        chk("underrun", {und1, und0}, {m_und, m_und});
        chk("ready_end", {rdy1, rdy0}, {2{!m_full && mode != 0}});
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int len, fa;
        repeat (3) @(negedge clk);
        chk("reset_dat", {dat1, dat0}, 2'b00);
        chk("reset_ready", {rdy1, rdy0}, 2'b00);
        chk("reset_underrun", {und1, und0}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        half(40, 3, E_START, 20, 16'hF2CF);
        half(40, -1, E_NONE, 20, 16'h83C1);
        half(40, -1, E_NONE, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        half(40, -1, E_NONE, 20, 16'h9C58);
        half(40, 5, E_PAUSE, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        half(40, 30, E_START, 20, 16'($urandom()));
        half(40, -1, E_NONE, 20, 16'($urandom()));
        half(40, -1, E_NONE, -1, '0);
        for (int k = 0; k < 24; k++) begin
            len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 4)) : 40;
            fa = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(len - 2, 1));
            half(len, -1, E_NONE, fa, 16'($urandom()));
        end
        half(40, -1, E_NONE, 20, 16'($urandom()));
        half(40, 8, E_STOP, -1, '0);
        half(40, 3, E_START, 20, 16'($urandom()));
        half(40, 4, E_STOPSTART, -1, '0);
        half(40, 3, E_START, 20, 16'($urandom()));
        half(40, 7, E_RST, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        half(40, -1, E_NONE, -1, '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
